imem_loader: RTL

Boot-time program loader that writes instruction memory for the pipelined RISC-V core. It receives a framed little-endian byte stream over a valid/ready interface and assembles 32-bit instruction words. Each word is written to consecutive instruction-memory word addresses. The core is held in reset (`core_reset`) until a complete, checksum-verified image is stored. This block writes the same memory the core's fetch stage reads.

---
 rtl/imem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into 32-bit words and writes instruction memory.
// Latency: write strobe one cycle after a word's 4th byte; done/error one cycle after the final frame byte.
// Backpressure: in_ready is high in every frame-receiving state, low in DONE/ERR and while reset is high.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    // Largest legal word count; compared on 17 bits so a full 16-bit count cannot alias.
    localparam logic [16:0]       CAP    = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;      // word count from the header
    logic [15:0]       idx_q, idx_d;      // index of the word being assembled
    logic [1:0]        lane_q, lane_d;    // byte position within the current word
    logic [23:0]       asm_q, asm_d;      // first three bytes of the current word
    logic [7:0]        csum_q, csum_d;    // running XOR of payload bytes
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        ecode_q, ecode_d;

    logic              rx_state;
    logic              accept;
    logic [15:0]       hdr_n;

    assign rx_state   = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign in_ready   = rx_state && !reset;
    assign accept     = in_valid && in_ready;
    assign hdr_n      = {in_data, cnt_q[7:0]};

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign err_code   = ecode_q;

    // Frame parser: next state, word assembly, checksum and write-port next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ecode_d = ecode_q;

        case (state_q)
            S_HDR0: begin
                if (accept) begin
                    cnt_d[7:0] = in_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    cnt_d = hdr_n;
                    if ({1'b0, hdr_n} > CAP) begin
                        state_d = S_ERR;
                        ecode_d = 2'b01;
                    end else if (hdr_n == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    asm_d[7:0]   = in_data;
                        2'd1:    asm_d[15:8]  = in_data;
                        2'd2:    asm_d[23:16] = in_data;
                        default: begin
                            // Fourth byte completes the word: register the write.
                            we_d    = 1'b1;
                            wdata_d = {in_data, asm_q};
                            addr_d  = BASE_A + ADDR_W'(idx_q);
                            idx_d   = idx_q + 16'd1;
                            if (idx_q == cnt_q - 16'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        ecode_d = 2'b10;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    // Re-arm: all per-frame bookkeeping clears on the way into HDR0.
                    state_d = S_HDR0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    csum_d  = '0;
                    addr_d  = BASE_A;
                    ecode_d = 2'b00;
                end
            end
            default: begin
                state_d = S_HDR0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; memory contents are never touched here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HDR0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_A;
            wdata_q <= '0;
            ecode_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ecode_q <= ecode_d;
        end
    end

endmodule
